decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter REG_AW, 5, register-address width; register count is 2**REG_AW.
REQ-002 Parameter IMM_W, 16, width of the branch immediate and memory-address field; SHALL be 8..16, taken from instr[IMM_W-1:0].
REQ-003 Parameter CNT_W, 16, width of the hazard-stall counter.
REQ-004 One clock; reset is synchronous and active-high; ports named clk and reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1, in_ready  out  1, in_instr  in  32: fetch-side instruction handshake.
REQ-008 flush  in  1  squash held and incoming instruction (branch taken downstream).
REQ-009 ex_load_valid  in  1, ex_load_rd  in  REG_AW: load currently in EX and its destination.
REQ-010 out_valid  out  1, out_ready  in  1: execute-side handshake.
REQ-011 out_ra, out_rb, out_rd  out  REG_AW each: source A, source B, destination.
REQ-012 out_ww  out  2, out_op  out  6, out_ppp  out  3, out_br  out  2, out_imm  out  IMM_W, out_mem_addr  out  IMM_W.
REQ-013 out_wen, out_mem_en, out_store, out_load, out_illegal  out  1 each.
REQ-014 stall_count  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-015 Decode: R 101010 (ra=[20:16], rb=[15:11], rd=[25:21], ww=[7:6], op=[5:0], wen=1); VBNZ 100010 (ra=[25:21], br=10, imm); VBEZ 100011 (ra=[25:21], br=11, imm); LD 100000 (rd=[25:21], mem_addr, mem_en=1, load=1, wen=1); SD 100001 (ra=[25:21], mem_addr, mem_en=1, store=1); NOP 111100; ppp=[10:8] for every opcode.
REQ-016 Every field an opcode does not define SHALL be 0; register fields SHALL take the low REG_AW bits of the 5-bit instruction fields.
REQ-017 Any other opcode SHALL decode as NOP with out_illegal=1; decode logic SHALL be fully specified with no latches.
REQ-018 Source use: R uses ra and rb; VBNZ, VBEZ and SD use ra; LD and NOP use none.
REQ-019 Hazard = in_valid && ex_load_valid && a used source equals ex_load_rd.
REQ-020 in_ready = !flush && !hazard && (!out_valid || out_ready).
REQ-021 Accept (in_valid && in_ready) SHALL register the decoded fields and set out_valid on the next edge; latency is 1 cycle.
REQ-022 out_valid && !out_ready: all outputs SHALL be held stable.
REQ-023 Output consumed with no accept in the same cycle: out_valid SHALL drop to 0 on the next edge.
REQ-024 Consume and accept in the same cycle: the new instruction SHALL replace the old with no bubble.
REQ-025 Flush: out_valid SHALL be 0 on the next edge; the same-cycle in_instr is not accepted; flush takes priority over hold and accept.
REQ-026 stall_count SHALL increment each cycle hazard=1 and flush=0, and SHALL hold at all-ones.
REQ-027 When out_valid=0, the data outputs SHALL keep their last values; the consumer SHALL ignore them.

Reset
REQ-028 On reset: out_valid=0, stall_count=0, and every data/control output =0.
REQ-029 Reset SHALL discard any held instruction and override flush, hazard and handshakes in that cycle.

Structure
REQ-030 Package decode_pkg SHALL hold the opcode constants, the BR encodings (00 none, 10 NZ, 11 EZ) and a packed decoded-control struct.
REQ-031 The combinational decoder SHALL be one sub-module, decode_comb; decode_stage adds the register, handshake, hazard and counter logic.

Verification
REQ-032 R-type 0xA8221885 (rd=1, ra=2, rb=3, ppp=000, ww=10, op=000101), out_ready=1 -> next cycle out_valid=1, rd=1, ra=2, rb=3, ww=10, op=5, wen=1.
REQ-033 LD rd=4 in EX (ex_load_valid=1, ex_load_rd=4), then R-type with ra=4 held 3 cycles -> in_ready=0 for those cycles, stall_count=3; drop ex_load_valid -> accepted the next cycle.
REQ-034 Accept while out_ready=0 for 5 cycles -> outputs constant, in_ready=0; raise out_ready together with a new in_valid -> back-to-back delivery with no bubble.
REQ-035 Opcode 000000 -> out_illegal=1, wen=mem_en=store=load=0, br=00.
REQ-036 Flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, incoming instruction dropped; reset mid-stall -> out_valid=0, stall_count=0.
REQ-037 CNT_W=4 with a hazard held 20 cycles -> stall_count saturates at 15.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode constants, branch encodings and the decoded-control record
// used by the decode stage and its combinational decoder.
package decode_pkg;

   localparam logic [5:0] OP_R    = 6'b101010;
   localparam logic [5:0] OP_VBNZ = 6'b100010;
   localparam logic [5:0] OP_VBEZ = 6'b100011;
   localparam logic [5:0] OP_LD   = 6'b100000;
   localparam logic [5:0] OP_SD   = 6'b100001;
   localparam logic [5:0] OP_NOP  = 6'b111100;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_NZ   = 2'b10,
      BR_EZ   = 2'b11
   } br_e;

   // Register fields are kept at the full 5-bit instruction width and the
   // immediate at its widest; the stage trims them to its parameters.
   typedef struct packed {
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rd;
      logic [1:0]  ww;
      logic [5:0]  op;
      logic [2:0]  ppp;
      br_e         br;
      logic [15:0] imm;
      logic [15:0] memAddr;
      logic        wen;
      logic        memEn;
      logic        store;
      logic        load;
      logic        illegal;
   } dec_ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side, execute-side and hazard-feedback signals of the decode stage.
// The master modport is the environment driving the stage; slave is the stage.
interface decode_stage_if #(
   parameter int REG_AW = 5,
   parameter int IMM_W  = 16,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic              flush;
   logic              ex_load_valid;
   logic [REG_AW-1:0] ex_load_rd;
   logic              out_valid;
   logic              out_ready;
   logic [REG_AW-1:0] out_ra;
   logic [REG_AW-1:0] out_rb;
   logic [REG_AW-1:0] out_rd;
   logic [1:0]        out_ww;
   logic [5:0]        out_op;
   logic [2:0]        out_ppp;
   logic [1:0]        out_br;
   logic [IMM_W-1:0]  out_imm;
   logic [IMM_W-1:0]  out_mem_addr;
   logic              out_wen;
   logic              out_mem_en;
   logic              out_store;
   logic              out_load;
   logic              out_illegal;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output in_valid, in_instr, flush, ex_load_valid, ex_load_rd, out_ready,
      input  in_ready, out_valid, out_ra, out_rb, out_rd, out_ww, out_op,
             out_ppp, out_br, out_imm, out_mem_addr, out_wen, out_mem_en,
             out_store, out_load, out_illegal, stall_count
   );

   modport slave (
      input  in_valid, in_instr, flush, ex_load_valid, ex_load_rd, out_ready,
      output in_ready, out_valid, out_ra, out_rb, out_rd, out_ww, out_op,
             out_ppp, out_br, out_imm, out_mem_addr, out_wen, out_mem_en,
             out_store, out_load, out_illegal, stall_count
   );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder; also reports which source
// registers the instruction actually reads, for load-use hazard detection.
module decode_comb
   import decode_pkg::*;
#(
   parameter int IMM_W = 16
) (
   input  logic [31:0] instr_i,
   output dec_ctrl_t   ctrl_o,
   output logic        useRa_o,
   output logic        useRb_o
);

   logic [15:0] immField;

   // Immediate and memory address share the low IMM_W bits, zero-extended.
   assign immField = 16'(instr_i[IMM_W-1:0]);

   always_comb begin
      ctrl_o     = '0;
      useRa_o    = 1'b0;
      useRb_o    = 1'b0;
      ctrl_o.ppp = instr_i[10:8];
      case (instr_i[31:26])
         OP_R: begin
            ctrl_o.ra  = instr_i[20:16];
            ctrl_o.rb  = instr_i[15:11];
            ctrl_o.rd  = instr_i[25:21];
            ctrl_o.ww  = instr_i[7:6];
            ctrl_o.op  = instr_i[5:0];
            ctrl_o.wen = 1'b1;
            useRa_o    = 1'b1;
            useRb_o    = 1'b1;
         end
         OP_VBNZ: begin
            ctrl_o.ra  = instr_i[25:21];
            ctrl_o.br  = BR_NZ;
            ctrl_o.imm = immField;
            useRa_o    = 1'b1;
         end
         OP_VBEZ: begin
            ctrl_o.ra  = instr_i[25:21];
            ctrl_o.br  = BR_EZ;
            ctrl_o.imm = immField;
            useRa_o    = 1'b1;
         end
         OP_LD: begin
            ctrl_o.rd      = instr_i[25:21];
            ctrl_o.memAddr = immField;
            ctrl_o.memEn   = 1'b1;
            ctrl_o.load    = 1'b1;
            ctrl_o.wen     = 1'b1;
         end
         OP_SD: begin
            ctrl_o.ra      = instr_i[25:21];
            ctrl_o.memAddr = immField;
            ctrl_o.memEn   = 1'b1;
            ctrl_o.store   = 1'b1;
            useRa_o        = 1'b1;
         end
         OP_NOP: begin
         end
         default: begin
            ctrl_o.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: one-deep output register with valid/ready handshake,
// load-use hazard stalling, flush squashing and a saturating stall counter.
module decode_stage
   import decode_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int IMM_W  = 16,
   parameter int CNT_W  = 16
) (
   input logic          clk,
   input logic          reset,
   decode_stage_if.slave bus
);

   dec_ctrl_t         decoded;
   dec_ctrl_t         ctrl_d, ctrl_q;
   logic              valid_d, valid_q;
   logic [CNT_W-1:0]  stall_d, stall_q;
   logic              useRa, useRb;
   logic [REG_AW-1:0] raSel, rbSel;
   logic              hazard, inReady, accept;

   decode_comb #(.IMM_W(IMM_W)) u_decode_comb (
      .instr_i (bus.in_instr),
      .ctrl_o  (decoded),
      .useRa_o (useRa),
      .useRb_o (useRb)
   );

   assign raSel = decoded.ra[REG_AW-1:0];
   assign rbSel = decoded.rb[REG_AW-1:0];

   // Only sources the instruction really reads can collide with the load in EX.
   assign hazard = bus.in_valid && bus.ex_load_valid &&
                   ((useRa && (raSel == bus.ex_load_rd)) ||
                    (useRb && (rbSel == bus.ex_load_rd)));

   assign inReady = !bus.flush && !hazard && (!valid_q || bus.out_ready);
   assign accept  = bus.in_valid && inReady;

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      stall_d = stall_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         ctrl_d  = decoded;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end
      if (hazard && !bus.flush && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         stall_q <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         stall_q <= stall_d;
      end
   end

   assign bus.in_ready     = inReady;
   assign bus.out_valid    = valid_q;
   assign bus.out_ra       = ctrl_q.ra[REG_AW-1:0];
   assign bus.out_rb       = ctrl_q.rb[REG_AW-1:0];
   assign bus.out_rd       = ctrl_q.rd[REG_AW-1:0];
   assign bus.out_ww       = ctrl_q.ww;
   assign bus.out_op       = ctrl_q.op;
   assign bus.out_ppp      = ctrl_q.ppp;
   assign bus.out_br       = ctrl_q.br;
   assign bus.out_imm      = ctrl_q.imm[IMM_W-1:0];
   assign bus.out_mem_addr = ctrl_q.memAddr[IMM_W-1:0];
   assign bus.out_wen      = ctrl_q.wen;
   assign bus.out_mem_en   = ctrl_q.memEn;
   assign bus.out_store    = ctrl_q.store;
   assign bus.out_load     = ctrl_q.load;
   assign bus.out_illegal  = ctrl_q.illegal;
   assign bus.stall_count  = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of decode vectors plus hand-written
// hazard, hold, flush, reset and counter-saturation sequences.
module tb_decode_stage;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   decode_stage_if #(.REG_AW(5), .IMM_W(16), .CNT_W(16)) bus ();
   decode_stage_if #(.REG_AW(5), .IMM_W(16), .CNT_W(4))  bus4 ();

   decode_stage #(.REG_AW(5), .IMM_W(16), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   decode_stage #(.REG_AW(5), .IMM_W(16), .CNT_W(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [1:0]  ww;
      logic [5:0]  op;
      logic [2:0]  ppp;
      logic [1:0]  br;
      logic [15:0] imm;
      logic [15:0] mem;
      logic [4:0]  flags;
   } vec_t;

   int   testsRun    = 0;
   int   testsFailed = 0;
   vec_t vecs [8];
   vec_t zeroVec;
   vec_t hazVec;

   function automatic vec_t mkVec(input logic [31:0] instr, input logic [4:0] rd,
                                  input logic [4:0] ra, input logic [4:0] rb,
                                  input logic [1:0] ww, input logic [5:0] op,
                                  input logic [2:0] ppp, input logic [1:0] br,
                                  input logic [15:0] imm, input logic [15:0] mem,
                                  input logic [4:0] flags);
      vec_t v;
      v.instr = instr; v.rd = rd; v.ra = ra; v.rb = rb; v.ww = ww; v.op = op;
      v.ppp = ppp; v.br = br; v.imm = imm; v.mem = mem; v.flags = flags;
      return v;
   endfunction

   // Flags order: wen, mem_en, store, load, illegal.
   function automatic logic [127:0] packExp(input vec_t v);
      return {63'd0, v.rd, v.ra, v.rb, v.ww, v.op, v.ppp, v.br, v.imm, v.mem, v.flags};
   endfunction

   function automatic logic [127:0] packAct();
      return {63'd0, bus.out_rd, bus.out_ra, bus.out_rb, bus.out_ww, bus.out_op,
              bus.out_ppp, bus.out_br, bus.out_imm, bus.out_mem_addr, bus.out_wen,
              bus.out_mem_en, bus.out_store, bus.out_load, bus.out_illegal};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic inValid, input logic [31:0] instr,
                                input logic fl, input logic exValid,
                                input logic [4:0] exRd, input logic outReady);
      bus.in_valid      = inValid;
      bus.in_instr      = instr;
      bus.flush         = fl;
      bus.ex_load_valid = exValid;
      bus.ex_load_rd    = exRd;
      bus.out_ready     = outReady;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = mkVec(32'hA8221885, 5'd1, 5'd2, 5'd3, 2'b10, 6'd5, 3'd0, 2'b00,
                      16'h0000, 16'h0000, 5'b10000);
      vecs[1] = mkVec({6'b100010, 5'd7, 5'd9, 16'h1234}, 5'd0, 5'd7, 5'd0, 2'b00,
                      6'd0, 3'd2, 2'b10, 16'h1234, 16'h0000, 5'b00000);
      vecs[2] = mkVec({6'b100011, 5'd31, 5'd0, 16'hFF00}, 5'd0, 5'd31, 5'd0, 2'b00,
                      6'd0, 3'd7, 2'b11, 16'hFF00, 16'h0000, 5'b00000);
      vecs[3] = mkVec({6'b100000, 5'd4, 5'd3, 16'h0A5C}, 5'd4, 5'd0, 5'd0, 2'b00,
                      6'd0, 3'd2, 2'b00, 16'h0000, 16'h0A5C, 5'b11010);
      vecs[4] = mkVec({6'b100001, 5'd12, 5'd1, 16'h8001}, 5'd0, 5'd12, 5'd0, 2'b00,
                      6'd0, 3'd0, 2'b00, 16'h0000, 16'h8001, 5'b01100);
      vecs[5] = mkVec({6'b111100, 26'h3FFFFFF}, 5'd0, 5'd0, 5'd0, 2'b00,
                      6'd0, 3'd7, 2'b00, 16'h0000, 16'h0000, 5'b00000);
      vecs[6] = mkVec({6'b000000, 26'h3FFFFFF}, 5'd0, 5'd0, 5'd0, 2'b00,
                      6'd0, 3'd7, 2'b00, 16'h0000, 16'h0000, 5'b00001);
      vecs[7] = mkVec({6'b111111, 5'd3, 5'd3, 16'h0300}, 5'd0, 5'd0, 5'd0, 2'b00,
                      6'd0, 3'd3, 2'b00, 16'h0000, 16'h0000, 5'b00001);
      zeroVec = mkVec(32'h0, 5'd0, 5'd0, 5'd0, 2'b00, 6'd0, 3'd0, 2'b00,
                      16'h0000, 16'h0000, 5'b00000);
      hazVec  = mkVec({6'b101010, 5'd6, 5'd4, 5'd8, 3'b001, 2'b01, 6'd9}, 5'd6, 5'd4,
                      5'd8, 2'b01, 6'd9, 3'd1, 2'b00, 16'h0000, 16'h0000, 5'b10000);

      bus4.in_valid      = 1'b0;
      bus4.in_instr      = 32'h0;
      bus4.flush         = 1'b0;
      bus4.ex_load_valid = 1'b0;
      bus4.ex_load_rd    = 5'd0;
      bus4.out_ready     = 1'b1;

      // Reset state
      reset = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
      tick();
      tick();
      checkOutput("reset_valid", 128'(bus.out_valid), 128'd0);
      checkOutput("reset_stall", 128'(bus.stall_count), 128'd0);
      checkOutput("reset_fields", packAct(), packExp(zeroVec));
      reset = 1'b0;
      #1;
      checkOutput("idle_ready", 128'(bus.in_ready), 128'd1);

      // Decode table, streamed back to back
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, vecs[i].instr, 1'b0, 1'b0, 5'd0, 1'b1);
         checkOutput($sformatf("vec%0d_ready", i), 128'(bus.in_ready), 128'd1);
         tick();
         checkOutput($sformatf("vec%0d_valid", i), 128'(bus.out_valid), 128'd1);
         checkOutput($sformatf("vec%0d_fields", i), packAct(), packExp(vecs[i]));
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
      tick();
      checkOutput("drain_valid", 128'(bus.out_valid), 128'd0);
      checkOutput("drain_keep", packAct(), packExp(vecs[7]));

      // Load-use hazard: only sources actually read matter
      applyStimulus(1'b1, {6'b100000, 5'd4, 5'd4, 16'h0}, 1'b0, 1'b1, 5'd4, 1'b1);
      checkOutput("ld_no_src_ready", 128'(bus.in_ready), 128'd1);
      applyStimulus(1'b1, {6'b101010, 5'd0, 5'd1, 5'd4, 11'd0}, 1'b0, 1'b1, 5'd4, 1'b1);
      checkOutput("rb_hazard_ready", 128'(bus.in_ready), 128'd0);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, hazVec.instr, 1'b0, 1'b1, 5'd4, 1'b1);
         checkOutput($sformatf("haz%0d_ready", c), 128'(bus.in_ready), 128'd0);
         tick();
      end
      checkOutput("haz_stall3", 128'(bus.stall_count), 128'd3);
      checkOutput("haz_valid", 128'(bus.out_valid), 128'd0);
      applyStimulus(1'b1, hazVec.instr, 1'b0, 1'b0, 5'd4, 1'b1);
      checkOutput("haz_clear_ready", 128'(bus.in_ready), 128'd1);
      tick();
      checkOutput("haz_accept_valid", 128'(bus.out_valid), 128'd1);
      checkOutput("haz_accept_fields", packAct(), packExp(hazVec));
      checkOutput("haz_stall_held", 128'(bus.stall_count), 128'd3);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
      tick();

      // Backpressure hold, then back-to-back release
      applyStimulus(1'b1, vecs[1].instr, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, vecs[3].instr, 1'b0, 1'b0, 5'd0, 1'b0);
         checkOutput($sformatf("hold%0d_ready", c), 128'(bus.in_ready), 128'd0);
         checkOutput($sformatf("hold%0d_valid", c), 128'(bus.out_valid), 128'd1);
         checkOutput($sformatf("hold%0d_fields", c), packAct(), packExp(vecs[1]));
         tick();
      end
      applyStimulus(1'b1, vecs[3].instr, 1'b0, 1'b0, 5'd0, 1'b1);
      checkOutput("release_ready", 128'(bus.in_ready), 128'd1);
      tick();
      checkOutput("b2b1_valid", 128'(bus.out_valid), 128'd1);
      checkOutput("b2b1_fields", packAct(), packExp(vecs[3]));
      applyStimulus(1'b1, vecs[4].instr, 1'b0, 1'b0, 5'd0, 1'b1);
      tick();
      checkOutput("b2b2_valid", 128'(bus.out_valid), 128'd1);
      checkOutput("b2b2_fields", packAct(), packExp(vecs[4]));
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
      tick();
      checkOutput("consume_valid", 128'(bus.out_valid), 128'd0);

      // Flush beats hold and accept; a flushed hazard is not counted
      applyStimulus(1'b1, vecs[0].instr, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      applyStimulus(1'b1, vecs[4].instr, 1'b1, 1'b0, 5'd0, 1'b0);
      checkOutput("flush_ready", 128'(bus.in_ready), 128'd0);
      tick();
      checkOutput("flush_valid", 128'(bus.out_valid), 128'd0);
      checkOutput("flush_dropped", packAct(), packExp(vecs[0]));
      applyStimulus(1'b1, hazVec.instr, 1'b1, 1'b1, 5'd4, 1'b1);
      tick();
      checkOutput("flush_haz_stall", 128'(bus.stall_count), 128'd3);
      checkOutput("flush_haz_valid", 128'(bus.out_valid), 128'd0);

      // Reset in the middle of a stall
      applyStimulus(1'b1, vecs[3].instr, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      applyStimulus(1'b1, hazVec.instr, 1'b0, 1'b1, 5'd4, 1'b0);
      tick();
      tick();
      checkOutput("prereset_stall", 128'(bus.stall_count), 128'd5);
      checkOutput("prereset_valid", 128'(bus.out_valid), 128'd1);
      reset = 1'b1;
      tick();
      checkOutput("midreset_valid", 128'(bus.out_valid), 128'd0);
      checkOutput("midreset_stall", 128'(bus.stall_count), 128'd0);
      checkOutput("midreset_fields", packAct(), packExp(zeroVec));
      reset = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);

      // Narrow counter saturates at all-ones
      bus4.in_valid      = 1'b1;
      bus4.in_instr      = hazVec.instr;
      bus4.ex_load_valid = 1'b1;
      bus4.ex_load_rd    = 5'd4;
      #1;
      checkOutput("sat_ready", 128'(bus4.in_ready), 128'd0);
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 14) checkOutput("sat_14", 128'(bus4.stall_count), 128'd14);
         if (c == 15) checkOutput("sat_15", 128'(bus4.stall_count), 128'd15);
      end
      checkOutput("sat_20", 128'(bus4.stall_count), 128'd15);
      checkOutput("sat_main_idle", 128'(bus.stall_count), 128'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
